data_loop_controller: RTL and testbench
=======================================

Name: data_loop_controller

Overview:
Consumer end of the main-controller/data-controller handshake. Each time data_prepare_i asserts, it captures the block geometry, input-depth index and size type. It then issues one tile request per block, in row-major order, to the tile-fetch/PE datapath over a valid/ready interface, and tracks tiles still in flight. When every tile has been accepted and reported done, it returns a single-cycle loop_finished_o pulse to the main controller.

Parameters:
MAX_OUTSTANDING, 4, maximum tiles accepted but not yet reported done (1..15).
CNT_W, 4, width of the outstanding-tile counter; must hold MAX_OUTSTANDING.

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous reset, active-low
data_prepare_i  input  1  level request from the main controller: start a loop
block_width_i  input  8  tiles per row; 0 treated as 1
block_height_i  input  8  tile rows; 0 treated as 1
data_id_i  input  4  input-depth index for this loop
size_type_i  input  1  tile size type for this loop
tile_valid_o  output  1  tile request valid
tile_ready_i  input  1  datapath accepts the tile request
tile_row_o  output  8  row index of the tile request
tile_col_o  output  8  column index of the tile request
tile_id_o  output  4  latched data_id
tile_size_type_o  output  1  latched size_type
tile_last_o  output  1  request is the final tile of the loop
tile_done_i  input  1  single-cycle pulse: one accepted tile has completed
busy_o  output  1  high in any state other than IDLE
loop_finished_o  output  1  single-cycle pulse: loop complete

Behaviour:
- Reset (async, reset_n=0): state=IDLE. All outputs 0. row, col and outstanding counters 0. Latched fields 0.
- IDLE: when data_prepare_i=1, latch width, height, id and size_type (0 is replaced by 1), clear row/col/outstanding, and go to ISSUE on the next edge.
- ISSUE:
  - tile_valid_o = (outstanding < MAX_OUTSTANDING), combinational from registered state.
  - Accept = tile_valid_o & tile_ready_i.
  - On accept: col+1. If col == width-1, col wraps to 0 and row increments.
  - tile_last_o = (row == height-1) & (col == width-1).
  - Accepting the last tile moves the FSM to DRAIN.
  - While valid is high and ready is low, row, col, last and the latched fields are held stable.
- Outstanding counter, updated in every state:
  - +1 on accept; -1 on tile_done_i; unchanged if both occur in the same cycle.
  - tile_done_i while outstanding==0 (and no accept in that cycle) is ignored; the counter never underflows.
- DRAIN: tile_valid_o=0. When the registered outstanding==0, go to DONE and assert loop_finished_o for exactly the first DONE cycle (registered output).
- DONE: loop_finished_o=0 after the first cycle. Wait for data_prepare_i=0, then go to IDLE. This prevents a retrigger while the main controller is still in its prepare phase. The main controller drops data_prepare for at least one cycle after each loop_finished pulse.
- data_prepare_i deasserting during ISSUE or DRAIN is ignored; the loop always runs to completion.
- Latency, width=1, height=1, ready=1, done returned N cycles after accept:
  - prepare seen at edge T0 → valid at T1, accepted at T1;
  - DRAIN from T2;
  - loop_finished_o one cycle after the cycle in which outstanding reaches 0.
- Total tiles per loop = width×height (max 255×255); row/col arithmetic is 8-bit and never exceeds its bound.

Optional Feature:
DATA_LOOP_PERF_EN:
- Defined: adds output loop_cycles_o [15:0].
  - Cleared when leaving IDLE.
  - Increments every cycle in ISSUE/DRAIN, saturating at 16'hFFFF.
  - Holds its value through DONE and IDLE until the next loop starts. Reset value 0.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- width=2, height=2, id=3, size=1, ready=1, done returned 2 cycles after each accept → four requests (0,0),(0,1),(1,0),(1,1) with tile_id_o=3 and tile_size_type_o=1; tile_last_o only on (1,1); exactly one loop_finished_o pulse.
- width=3, height=1, ready toggling 1/0 → row/col/last held stable during every stall; three accepts total; no duplicated or skipped column.
- MAX_OUTSTANDING=4, width=6, height=1, no tile_done_i until cycle 20 → valid drops after 4 accepts; resumes one cycle after the first done; finish comes only after all 6 done pulses.
- width=0, height=0 → treated as 1×1: a single tile (0,0) with last=1, then loop_finished_o.
- Main-controller model, total_od=4, total_id=2 → four loops, each started one cycle after data_prepare re-asserts; no retrigger while in DONE; accept and done in the same cycle leave outstanding unchanged.
- reset_n=0 asserted mid-ISSUE with outstanding=2 → all outputs 0 immediately; IDLE after release; a new prepare starts cleanly from (0,0).

Source files
------------

// File: rtl/data_loop_controller.sv
// data_loop_controller: consumer side of the main/data controller handshake.
// Latches the block geometry on data_prepare_i and issues one tile request per
// block in row-major order over valid/ready. It tracks tiles still in flight and
// pulses loop_finished_o once every accepted tile has reported done.
// Optional build macro DATA_LOOP_PERF_EN adds loop_cycles_o, a saturating
// count of the cycles spent in ISSUE and DRAIN for the most recent loop.
//
// state | meaning
// IDLE  | waiting for data_prepare_i
// ISSUE | issuing tile requests, throttled by MAX_OUTSTANDING
// DRAIN | all tiles accepted, waiting for outstanding to reach 0
// DONE  | loop_finished_o pulsed; waiting for data_prepare_i to drop
module data_loop_controller #(
   parameter int MAX_OUTSTANDING = 4,
   parameter int CNT_W           = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       data_prepare_i,
   input  logic [7:0] block_width_i,
   input  logic [7:0] block_height_i,
   input  logic [3:0] data_id_i,
   input  logic       size_type_i,
   output logic       tile_valid_o,
   input  logic       tile_ready_i,
   output logic [7:0] tile_row_o,
   output logic [7:0] tile_col_o,
   output logic [3:0] tile_id_o,
   output logic       tile_size_type_o,
   output logic       tile_last_o,
   input  logic       tile_done_i,
   output logic       busy_o,
   output logic       loop_finished_o
`ifdef DATA_LOOP_PERF_EN
   ,
   output logic [15:0] loop_cycles_o
`endif
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t           state, state_nxt;
   logic [7:0]       row, col, width, height;
   logic [3:0]       id;
   logic             size_type;
   logic [CNT_W-1:0] outstanding;
   logic             finished;
   logic             start, accept, col_end, row_end;

   assign start   = (state == IDLE) && data_prepare_i;
   assign col_end = (col == width - 8'd1);
   assign row_end = (row == height - 8'd1);

   assign tile_valid_o     = (state == ISSUE) && (outstanding < CNT_W'(MAX_OUTSTANDING));
   assign accept           = tile_valid_o && tile_ready_i;
   // Gated by ISSUE so that reset/IDLE (width=0 latched) never shows a stray last.
   assign tile_last_o      = (state == ISSUE) && col_end && row_end;
   assign tile_row_o       = row;
   assign tile_col_o       = col;
   assign tile_id_o        = id;
   assign tile_size_type_o = size_type;
   assign busy_o           = (state != IDLE);
   assign loop_finished_o  = finished;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic; the loop always runs to completion once started.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (data_prepare_i) state_nxt = ISSUE;
         ISSUE:   if (accept && tile_last_o) state_nxt = DRAIN;
         DRAIN:   if (outstanding == '0) state_nxt = DONE;
         DONE:    if (!data_prepare_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Loop fields and row-major tile position; the position holds on the final
   // accept so row never steps past height-1.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         width     <= '0;
         height    <= '0;
         id        <= '0;
         size_type <= 1'b0;
         row       <= '0;
         col       <= '0;
      end else if (start) begin
         width     <= (block_width_i  == 8'd0) ? 8'd1 : block_width_i;
         height    <= (block_height_i == 8'd0) ? 8'd1 : block_height_i;
         id        <= data_id_i;
         size_type <= size_type_i;
         row       <= '0;
         col       <= '0;
      end else if (accept && !tile_last_o) begin
         if (col_end) begin
            col <= '0;
            row <= row + 8'd1;
         end else begin
            col <= col + 8'd1;
         end
      end
   end

   // Tiles in flight: accept and done together cancel; a stray done at zero is dropped.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         outstanding <= '0;
      else if (start)
         outstanding <= '0;
      else if (accept && !tile_done_i)
         outstanding <= outstanding + CNT_W'(1);
      else if (tile_done_i && !accept && (outstanding != '0))
         outstanding <= outstanding - CNT_W'(1);
   end

   // Finish pulse, high for the first DONE cycle only.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) finished <= 1'b0;
      else          finished <= (state == DRAIN) && (outstanding == '0);
   end

`ifdef DATA_LOOP_PERF_EN
   // Saturating active-cycle counter, cleared as a new loop starts.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         loop_cycles_o <= '0;
      else if (start)
         loop_cycles_o <= '0;
      else if (((state == ISSUE) || (state == DRAIN)) && (loop_cycles_o != 16'hFFFF))
         loop_cycles_o <= loop_cycles_o + 16'd1;
   end
`endif

endmodule

// File: tb/tb_data_loop_controller.sv
// Directed testbench for data_loop_controller with hand-computed expectations.
module tb_data_loop_controller;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       prep;
   logic [7:0] bw, bh;
   logic [3:0] did;
   logic       sz;
   logic       valid;
   logic       ready;
   logic [7:0] row, col;
   logic [3:0] tid;
   logic       tsz;
   logic       last;
   logic       done;
   logic       busy;
   logic       fin;
`ifdef DATA_LOOP_PERF_EN
   logic [15:0] cycles;
`endif

   int n_vec = 0;
   int n_err = 0;

   data_loop_controller #(.MAX_OUTSTANDING(4), .CNT_W(4)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .data_prepare_i   (prep),
      .block_width_i    (bw),
      .block_height_i   (bh),
      .data_id_i        (did),
      .size_type_i      (sz),
      .tile_valid_o     (valid),
      .tile_ready_i     (ready),
      .tile_row_o       (row),
      .tile_col_o       (col),
      .tile_id_o        (tid),
      .tile_size_type_o (tsz),
      .tile_last_o      (last),
      .tile_done_i      (done),
      .busy_o           (busy),
      .loop_finished_o  (fin)
`ifdef DATA_LOOP_PERF_EN
      ,
      .loop_cycles_o    (cycles)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic req(input string tag, input logic v, input logic [7:0] r,
                      input logic [7:0] c, input logic l);
      chk({tag, "_valid"}, {15'd0, valid}, {15'd0, v});
      chk({tag, "_row"},   {8'd0, row},    {8'd0, r});
      chk({tag, "_col"},   {8'd0, col},    {8'd0, c});
      chk({tag, "_last"},  {15'd0, last},  {15'd0, l});
   endtask

   initial begin
      reset_n = 1'b0; prep = 1'b0; bw = '0; bh = '0; did = '0; sz = 1'b0;
      ready = 1'b0; done = 1'b0;
      tick(); tick();
      req("rst", 1'b0, 8'd0, 8'd0, 1'b0);
      chk("rst_busy", {15'd0, busy}, 16'd0);
      chk("rst_fin",  {15'd0, fin},  16'd0);
      chk("rst_id",   {12'd0, tid},  16'd0);
      chk("rst_sz",   {15'd0, tsz},  16'd0);
      reset_n = 1'b1;

      // 2x2 loop, ready=1, done returned two edges after each accept
      prep = 1'b1; bw = 8'd2; bh = 8'd2; did = 4'd3; sz = 1'b1; ready = 1'b1;
      tick();
      req("t1_r00", 1'b1, 8'd0, 8'd0, 1'b0);
      chk("t1_id",   {12'd0, tid}, 16'd3);
      chk("t1_sz",   {15'd0, tsz}, 16'd1);
      chk("t1_busy", {15'd0, busy}, 16'd1);
      prep = 1'b0;
      tick(); req("t1_r01", 1'b1, 8'd0, 8'd1, 1'b0);
      tick(); req("t1_r10", 1'b1, 8'd1, 8'd0, 1'b0);
      done = 1'b1;
      tick(); req("t1_r11", 1'b1, 8'd1, 8'd1, 1'b1);
      chk("t1_id11", {12'd0, tid}, 16'd3);
      tick();
      chk("t1_drain_valid", {15'd0, valid}, 16'd0);
      chk("t1_drain_fin",   {15'd0, fin},   16'd0);
      tick();
      tick(); done = 1'b0;
      chk("t1_fin_early", {15'd0, fin}, 16'd0);
      tick();
      chk("t1_fin", {15'd0, fin}, 16'd1);
`ifdef DATA_LOOP_PERF_EN
      chk("t1_cycles", cycles, 16'd7);
`endif
      tick();
      chk("t1_fin_off", {15'd0, fin},  16'd0);
      chk("t1_idle",    {15'd0, busy}, 16'd0);

      // 3x1 loop with ready toggling: position held during each stall
      prep = 1'b1; bw = 8'd3; bh = 8'd1; did = 4'd5; sz = 1'b0; ready = 1'b0;
      tick(); req("t2_c0", 1'b1, 8'd0, 8'd0, 1'b0);
      prep = 1'b0;
      tick(); req("t2_c0_stall", 1'b1, 8'd0, 8'd0, 1'b0);
      ready = 1'b1;
      tick(); req("t2_c1", 1'b1, 8'd0, 8'd1, 1'b0);
      ready = 1'b0;
      tick(); req("t2_c1_stall", 1'b1, 8'd0, 8'd1, 1'b0);
      ready = 1'b1;
      tick(); req("t2_c2", 1'b1, 8'd0, 8'd2, 1'b1);
      ready = 1'b0;
      tick(); req("t2_c2_stall", 1'b1, 8'd0, 8'd2, 1'b1);
      chk("t2_id", {12'd0, tid}, 16'd5);
      chk("t2_sz", {15'd0, tsz}, 16'd0);
      ready = 1'b1;
      tick();
      chk("t2_drain_valid", {15'd0, valid}, 16'd0);
      done = 1'b1;
      tick(); tick(); tick(); done = 1'b0;
      chk("t2_fin_early", {15'd0, fin}, 16'd0);
      tick(); chk("t2_fin", {15'd0, fin}, 16'd1);
      tick(); chk("t2_idle", {15'd0, busy}, 16'd0);

      // 6x1 loop, outstanding limit of 4, prepare held high throughout
      prep = 1'b1; bw = 8'd6; bh = 8'd1; did = 4'd1; sz = 1'b0; ready = 1'b1;
      tick(); req("t3_c0", 1'b1, 8'd0, 8'd0, 1'b0);
      tick(); tick(); tick();
      req("t3_c3", 1'b1, 8'd0, 8'd3, 1'b0);
      tick(); req("t3_full", 1'b0, 8'd0, 8'd4, 1'b0);
      tick(); tick(); tick(); tick();
      req("t3_full_hold", 1'b0, 8'd0, 8'd4, 1'b0);
      done = 1'b1;
      tick(); done = 1'b0;
      req("t3_resume", 1'b1, 8'd0, 8'd4, 1'b0);
      tick(); req("t3_full2", 1'b0, 8'd0, 8'd5, 1'b1);
      done = 1'b1;
      tick(); done = 1'b0;
      req("t3_resume2", 1'b1, 8'd0, 8'd5, 1'b1);
      tick();
      chk("t3_drain_valid", {15'd0, valid}, 16'd0);
      done = 1'b1;
      tick(); tick(); tick();
      chk("t3_fin_early3", {15'd0, fin}, 16'd0);
      tick(); done = 1'b0;
      chk("t3_fin_early4", {15'd0, fin}, 16'd0);
      tick(); chk("t3_fin", {15'd0, fin}, 16'd1);
      tick();
      chk("t3_fin_off",   {15'd0, fin},  16'd0);
      chk("t3_done_hold", {15'd0, busy}, 16'd1);
      chk("t3_no_retrig", {15'd0, valid}, 16'd0);
      prep = 1'b0;
      tick(); chk("t3_idle", {15'd0, busy}, 16'd0);

      // zero geometry behaves as a single 1x1 tile
      prep = 1'b1; bw = 8'd0; bh = 8'd0; did = 4'd2; sz = 1'b1; ready = 1'b1;
      tick(); req("t4_only", 1'b1, 8'd0, 8'd0, 1'b1);
      prep = 1'b0;
      tick(); chk("t4_drain_valid", {15'd0, valid}, 16'd0);
      done = 1'b1;
      tick(); done = 1'b0;
      chk("t4_fin_early", {15'd0, fin}, 16'd0);
      tick(); chk("t4_fin", {15'd0, fin}, 16'd1);
      tick(); chk("t4_idle", {15'd0, busy}, 16'd0);

      // accept and done in the same cycle at outstanding 0 leave it at 0
      prep = 1'b1; bw = 8'd2; bh = 8'd1; did = 4'd4; sz = 1'b0; ready = 1'b1; done = 1'b1;
      tick(); req("t5_c0", 1'b1, 8'd0, 8'd0, 1'b0);
      prep = 1'b0;
      tick(); done = 1'b0;
      req("t5_c1", 1'b1, 8'd0, 8'd1, 1'b1);
      tick(); tick();
      chk("t5_wait_one", {15'd0, fin}, 16'd0);
      done = 1'b1;
      tick(); done = 1'b0;
      chk("t5_fin_early", {15'd0, fin}, 16'd0);
      tick(); chk("t5_fin", {15'd0, fin}, 16'd1);
      tick(); chk("t5_idle", {15'd0, busy}, 16'd0);

      // main-controller model: four back-to-back 1x1 loops
      for (int k = 0; k < 4; k++) begin
         prep = 1'b1; bw = 8'd1; bh = 8'd1; did = 4'(k); sz = 1'b0; ready = 1'b1;
         tick();
         req("mc_tile", 1'b1, 8'd0, 8'd0, 1'b1);
         chk("mc_id", {12'd0, tid}, 16'(k));
         tick(); chk("mc_drain_valid", {15'd0, valid}, 16'd0);
         done = 1'b1;
         tick(); done = 1'b0;
         tick(); chk("mc_fin", {15'd0, fin}, 16'd1);
         tick();
         chk("mc_fin_off", {15'd0, fin},   16'd0);
         chk("mc_hold",    {15'd0, busy},  16'd1);
         chk("mc_no_req",  {15'd0, valid}, 16'd0);
         prep = 1'b0;
         tick(); chk("mc_idle", {15'd0, busy}, 16'd0);
      end

      // reset mid-ISSUE with two tiles outstanding
      prep = 1'b1; bw = 8'd4; bh = 8'd1; did = 4'd7; sz = 1'b1; ready = 1'b1;
      tick(); prep = 1'b0;
      tick(); tick();
      req("t6_pre", 1'b1, 8'd0, 8'd2, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      req("t6_rst", 1'b0, 8'd0, 8'd0, 1'b0);
      chk("t6_rst_busy", {15'd0, busy}, 16'd0);
      chk("t6_rst_id",   {12'd0, tid},  16'd0);
      chk("t6_rst_sz",   {15'd0, tsz},  16'd0);
      chk("t6_rst_fin",  {15'd0, fin},  16'd0);
      tick();
      reset_n = 1'b1;
      prep = 1'b1; bw = 8'd1; bh = 8'd1; did = 4'd9; sz = 1'b0;
      tick();
      req("t6_new", 1'b1, 8'd0, 8'd0, 1'b1);
      chk("t6_new_id", {12'd0, tid}, 16'd9);
      prep = 1'b0;
      tick(); done = 1'b1;
      tick(); done = 1'b0;
      tick(); chk("t6_fin", {15'd0, fin}, 16'd1);
      tick(); chk("t6_idle", {15'd0, busy}, 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
